// File: rtl/dbg_snapshot_streamer.sv
// Freezes an N_CH x NB_CH snapshot bus and streams it out byte by byte over a
// valid/ready link, with an optional XOR checksum trailer byte.
module dbg_snapshot_streamer #(
  parameter int NB_CH     = 32,
  parameter int N_CH      = 16,
  parameter int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1,
  parameter int CHKSUM_EN = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [N_CH*NB_CH-1:0] i_data,
  input  logic                  i_start,
  input  logic                  i_mode,
  input  logic [CH_W-1:0]       i_ch_sel,
  input  logic                  i_msb_first,
  input  logic                  i_abort,
  input  logic                  i_tx_ready,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_valid,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  localparam int BPC = NB_CH / 8;
  localparam int BW  = (BPC > 1) ? $clog2(BPC) : 1;
  localparam int IW  = $clog2(N_CH * NB_CH);

  typedef enum logic [1:0] {IDLE, SEND, CHK, DONE} state_e;

  state_e                state_q, state_d;
  logic [N_CH*NB_CH-1:0] shadow_q, shadow_d;
  logic [CH_W-1:0]       curCh_q, curCh_d;
  logic [CH_W-1:0]       lastCh_q, lastCh_d;
  logic [BW-1:0]         byteIdx_q, byteIdx_d;
  logic                  msbFirst_q, msbFirst_d;
  logic [7:0]            chkSum_q, chkSum_d;
  logic [7:0]            txData_q, txData_d;
  logic                  txValid_q, txValid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  xfer;
  logic                  lastByte;
  logic [CH_W-1:0]       firstCh;
  logic [CH_W-1:0]       nextCh;
  logic [BW-1:0]         nextByte;

  // Byte b of channel ch, counted from the top when msb is set.
  function automatic logic [7:0] pickByte(input logic [N_CH*NB_CH-1:0] src,
                                          input logic [CH_W-1:0] ch,
                                          input logic [BW-1:0] b,
                                          input logic msb);
    int            pos;
    logic [IW-1:0] idx;
    pos = msb ? (BPC - 1 - int'(b)) : int'(b);
    idx = IW'(int'(ch) * NB_CH + pos * 8);
    return src[idx +: 8];
  endfunction

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= IDLE;
      shadow_q   <= '0;
      curCh_q    <= '0;
      lastCh_q   <= '0;
      byteIdx_q  <= '0;
      msbFirst_q <= 1'b0;
      chkSum_q   <= '0;
      txData_q   <= '0;
      txValid_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      curCh_q    <= curCh_d;
      lastCh_q   <= lastCh_d;
      byteIdx_q  <= byteIdx_d;
      msbFirst_q <= msbFirst_d;
      chkSum_q   <= chkSum_d;
      txData_q   <= txData_d;
      txValid_q  <= txValid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // The next byte is looked up one cycle ahead so every output stays registered.
  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    curCh_d    = curCh_q;
    lastCh_d   = lastCh_q;
    byteIdx_d  = byteIdx_q;
    msbFirst_d = msbFirst_q;
    chkSum_d   = chkSum_q;
    txData_d   = txData_q;
    txValid_d  = txValid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    xfer     = txValid_q & i_tx_ready;
    lastByte = (byteIdx_q == BW'(BPC - 1));
    firstCh  = i_mode ? i_ch_sel : '0;
    nextCh   = curCh_q + CH_W'(1);
    nextByte = byteIdx_q + BW'(1);

    unique case (state_q)
      IDLE: begin
        txValid_d = 1'b0;
        busy_d    = 1'b0;
        if (i_start) begin
          if (i_mode && (32'(i_ch_sel) >= N_CH)) begin
            err_d = 1'b1;
          end else begin
            shadow_d   = i_data;
            msbFirst_d = i_msb_first;
            curCh_d    = firstCh;
            lastCh_d   = i_mode ? i_ch_sel : CH_W'(N_CH - 1);
            byteIdx_d  = '0;
            chkSum_d   = '0;
            txData_d   = pickByte(i_data, firstCh, '0, i_msb_first);
            txValid_d  = 1'b1;
            busy_d     = 1'b1;
            state_d    = SEND;
          end
        end
      end
      SEND: begin
        if (i_abort) begin
          txValid_d = 1'b0;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end else if (xfer) begin
          chkSum_d = chkSum_q ^ txData_q;
          if (!lastByte) begin
            byteIdx_d = nextByte;
            txData_d  = pickByte(shadow_q, curCh_q, nextByte, msbFirst_q);
          end else if (curCh_q != lastCh_q) begin
            curCh_d   = nextCh;
            byteIdx_d = '0;
            txData_d  = pickByte(shadow_q, nextCh, '0, msbFirst_q);
          end else if (CHKSUM_EN != 0) begin
            txData_d = chkSum_q ^ txData_q;
            state_d  = CHK;
          end else begin
            txValid_d = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            state_d   = DONE;
          end
        end
      end
      CHK: begin
        if (i_abort) begin
          txValid_d = 1'b0;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end else if (xfer) begin
          txValid_d = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_tx_data  = txData_q;
  assign o_tx_valid = txValid_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_err      = err_q;

endmodule
